// File: rtl/bcd_display_pkg.sv
// Shared types and segment constants for the BCD display scanner.
// Segment order is {g,f,e,d,c,b,a}, active-high.
package bcd_display_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_ERR   = 7'h40;
  localparam seg_t SEG_BLANK = 7'h00;

endpackage : bcd_display_pkg

// File: rtl/bcd_display_scanner_if.sv
// Bus between the BCD counter side (master) and the display scanner (slave).
interface bcd_display_scanner_if #(
  parameter int unsigned DIGITS = 6
);
  import bcd_display_pkg::*;

  localparam int unsigned SEL_W  = $clog2(DIGITS);
  localparam int unsigned SNAP_W = DIGITS * BCD_W;

  logic [SNAP_W-1:0] bcd;
  logic              latch;
  seg_t              seg;
  logic              dp;
  logic [DIGITS-1:0] an;
  logic [SEL_W-1:0]  digit_sel;

  modport master (
    output bcd,
    output latch,
    input  seg,
    input  dp,
    input  an,
    input  digit_sel
  );

  modport slave (
    input  bcd,
    input  latch,
    output seg,
    output dp,
    output an,
    output digit_sel
  );

endinterface : bcd_display_scanner_if

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to 7-segment decoder; codes 10..15 show the "-" error glyph.
module bcd_to_7seg
  import bcd_display_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output seg_t             seg_c
);

  always_comb begin
    seg_c = SEG_ERR;
    case (bcd)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_ERR;
    endcase
  end

endmodule : bcd_to_7seg

// File: rtl/bcd_display_scanner.sv
// Multiplexed 7-segment scanner: snapshots a packed BCD word and drives one digit per slot
// with a one-cycle blanking gap. Optional build macro: LEADING_ZERO_BLANK_EN.
module bcd_display_scanner
  import bcd_display_pkg::*;
#(
  parameter int unsigned       DIGITS   = 6,
  parameter int unsigned       SCAN_DIV = 1024,
  parameter logic [DIGITS-1:0] DP_MASK  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_display_scanner_if.slave  bus
);

  localparam int unsigned SEL_W  = $clog2(DIGITS);
  localparam int unsigned PRE_W  = $clog2(SCAN_DIV);
  localparam int unsigned SNAP_W = DIGITS * BCD_W;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(DIGITS - 1);

  logic [SNAP_W-1:0] snap;
  logic [PRE_W-1:0]  prescaler;
  logic [SEL_W-1:0]  digit_sel;
  logic [DIGITS-1:0] an;
  seg_t              seg;
  logic              dp;

  logic              tick_c;
  logic              dead_c;
  logic [BCD_W-1:0]  cur_digit_c;
  logic              cur_dp_c;
  logic [DIGITS-1:0] cur_an_c;
  seg_t              dec_seg_c;
  logic              blank_c;
  seg_t              seg_next_c;

  assign tick_c   = (prescaler == PRE_LAST);
  assign dead_c   = (prescaler == '0);
  assign cur_an_c = DIGITS'(1) << digit_sel;

  // Select the snapshot nibble and decimal-point bit of the digit being scanned.
  always_comb begin
    cur_digit_c = '0;
    cur_dp_c    = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (SEL_W'(i) == digit_sel) begin
        cur_digit_c = snap[i*BCD_W +: BCD_W];
        cur_dp_c    = DP_MASK[i];
      end
    end
  end

  bcd_to_7seg u_dec (
    .bcd   (cur_digit_c),
    .seg_c (dec_seg_c)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // upper_zero_c[i]: snapshot digits i..DIGITS-1 are all zero (invalid codes count as nonzero).
  logic [DIGITS-1:0] upper_zero_c;

  always_comb begin
    upper_zero_c             = '0;
    upper_zero_c[DIGITS-1]   = (snap[SNAP_W-1 -: BCD_W] == '0);
    for (int unsigned i = 1; i < DIGITS; i++) begin
      upper_zero_c[DIGITS-1-i] = upper_zero_c[DIGITS-i] &
                                 (snap[(DIGITS-1-i)*BCD_W +: BCD_W] == '0);
    end
  end

  always_comb begin
    blank_c = 1'b0;
    for (int unsigned i = 1; i < DIGITS; i++) begin
      if (SEL_W'(i) == digit_sel) begin
        blank_c = upper_zero_c[i];
      end
    end
  end
`else
  assign blank_c = 1'b0;
`endif

  assign seg_next_c = blank_c ? SEG_BLANK : dec_seg_c;

  // Snapshot capture; transparent with a one-cycle lag while latch is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap <= '0;
    end else if (bus.latch) begin
      snap <= bus.bcd;
    end
  end

  // Slot timing: prescaler wraps every SCAN_DIV cycles and advances the scanned digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      digit_sel <= '0;
    end else begin
      prescaler <= tick_c ? '0 : prescaler + PRE_W'(1);
      if (tick_c) begin
        digit_sel <= (digit_sel == SEL_LAST) ? '0 : digit_sel + SEL_W'(1);
      end
    end
  end

  // Pad drivers; the first cycle of each slot is blanked to suppress ghosting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= '0;
      seg <= SEG_BLANK;
      dp  <= 1'b0;
    end else if (dead_c) begin
      an  <= '0;
      seg <= SEG_BLANK;
      dp  <= 1'b0;
    end else begin
      an  <= cur_an_c;
      seg <= seg_next_c;
      dp  <= cur_dp_c;
    end
  end

  assign bus.an        = an;
  assign bus.seg       = seg;
  assign bus.dp        = dp;
  assign bus.digit_sel = digit_sel;

endmodule : bcd_display_scanner
